// File: rtl/score_bcd_converter.sv
// score_bcd_converter
//   Sequential binary-to-BCD converter for the score path.
//   It uses shift-and-add-3 (double dabble) and shifts one bit per clock.
//   Latency is BIN_WIDTH+1 edges from the accepted start edge to done.
//
// Optional feature:
//   LEADING_ZERO_BLANK_EN  When defined, blank_mask flags the leading-zero
//                          digits (the ones digit is never flagged). When
//                          undefined, blank_mask is tied to zero.
//
// Ports:
//   clock       system clock, rising edge
//   resetn      asynchronous, active-low reset
//   start       conversion request; sampled only while busy=0
//   bin_in      unsigned binary score; sampled on the accepted start edge
//   busy        conversion in progress
//   done        one-cycle pulse; digits/overflow/blank_mask updated
//   digits      packed BCD; [3:0] = ones, [7:4] = tens, ...
//   overflow    last accepted bin_in exceeded 10^DIGITS - 1
//   blank_mask  per-digit blank flags
module score_bcd_converter #(
  parameter int BIN_WIDTH = 17,
  parameter int DIGITS    = 5
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                 state, state_next;
  logic [BIN_WIDTH-1:0]   shreg;
  logic [4*DIGITS-1:0]    bcd;
  logic [4*DIGITS-1:0]    bcd_adj;
  logic [CNT_W-1:0]       cnt;
  logic                   over;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add-3 correction on every nibble >= 5 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      over     <= 1'b0;
      done     <= 1'b0;
      digits   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= bin_in;
            bcd   <= '0;
            cnt   <= '0;
            over  <= (64'(bin_in) > MAX_VAL);
          end
        end
        SHIFT: begin
          bcd   <= {bcd_adj[4*DIGITS-2:0], shreg[BIN_WIDTH-1]};
          shreg <= {shreg[BIN_WIDTH-2:0], 1'b0};
          cnt   <= cnt + 1'b1;
        end
        FINISH: begin
          digits   <= over ? {DIGITS{4'h9}} : bcd;
          overflow <= over;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] mask_next;
  logic              zero_above;

  // Walk from the most-significant digit down; a digit is blanked while
  // it and everything above it is zero. Bit 0 stays clear.
  always_comb begin
    mask_next  = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      zero_above   = zero_above & (bcd[4*i +: 4] == 4'd0);
      mask_next[i] = zero_above;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)               blank_mask <= '0;
    else if (state == FINISH)  blank_mask <= over ? '0 : mask_next;
  end
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_score_bcd_converter.sv
module tb_score_bcd_converter;

  localparam int BW = 17;
  localparam int D  = 5;
  localparam int LAT = BW + 1;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [BW-1:0]     bin_in = '0;
  logic              busy;
  logic              done;
  logic [4*D-1:0]    digits;
  logic              overflow;
  logic [D-1:0]      blank_mask;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [4*D-1:0] dig;
    logic           ovf;
    logic [D-1:0]   mask;
    int             done_cyc;
  } exp_t;

  exp_t sb[$];

  score_bcd_converter #(.BIN_WIDTH(BW), .DIGITS(D)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .digits     (digits),
    .overflow   (overflow),
    .blank_mask (blank_mask)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [4*D-1:0] exp_dig(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned t;
    r = '0;
    if (v > 99999) begin
      for (int i = 0; i < D; i++) r[4*i +: 4] = 4'h9;
      return r;
    end
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] exp_mask(input int unsigned v);
    logic [D-1:0] r;
    int unsigned p;
    r = '0;
`ifdef LEADING_ZERO_BLANK_EN
    if (v <= 99999) begin
      p = 1;
      for (int i = 1; i < D; i++) begin
        p = p * 10;
        r[i] = (v < p);
      end
    end
`else
    p = v;
`endif
    return r;
  endfunction

  function automatic exp_t make_exp(input int unsigned v, input int dc);
    exp_t e;
    e.dig      = exp_dig(v);
    e.ovf      = (v > 99999);
    e.mask     = exp_mask(v);
    e.done_cyc = dc;
    return e;
  endfunction

  // Scoreboard checker: every done pulse pops one expectation
  always @(negedge clock) begin
    if (resetn) begin
      if (prev_done) begin
        checks++;
        assert (done === 1'b0) else begin
          failures++;
          $error("FAIL done_width observed=%b expected=0", done);
        end
      end
      if (done === 1'b1) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_done observed=1 expected=0 digits=%h", digits);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          assert (digits === e.dig) else begin
            failures++;
            $error("FAIL digits observed=%h expected=%h", digits, e.dig);
          end
          checks++;
          assert (overflow === e.ovf) else begin
            failures++;
            $error("FAIL overflow observed=%b expected=%b", overflow, e.ovf);
          end
          checks++;
          assert (blank_mask === e.mask) else begin
            failures++;
            $error("FAIL blank_mask observed=%b expected=%b", blank_mask, e.mask);
          end
          checks++;
          assert (cyc === e.done_cyc) else begin
            failures++;
            $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, e.done_cyc);
          end
          checks++;
          assert (busy === 1'b0) else begin
            failures++;
            $error("FAIL busy_at_done observed=%b expected=0", busy);
          end
          for (int i = 0; i < D; i++) begin
            checks++;
            assert (digits[4*i +: 4] <= 4'd9) else begin
              failures++;
              $error("FAIL nibble%0d observed=%h expected<=9", i, digits[4*i +: 4]);
            end
          end
        end
      end
    end
    prev_done = done;
  end

  // Called at a negedge; start is accepted on the following posedge
  task automatic launch(input int unsigned v);
    bin_in = BW'(v);
    start  = 1'b1;
    sb.push_back(make_exp(v, cyc + 1 + LAT));
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL drain_timeout pending=%0d expected=0", sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert ({busy, done, digits, overflow, blank_mask} === '0) else begin
      failures++;
      $error("FAIL %s observed busy=%b done=%b digits=%h ovf=%b mask=%b expected all 0",
             tag, busy, done, digits, overflow, blank_mask);
    end
  endtask

  initial begin
    int n;
    // Reset
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset_state");
    resetn = 1'b1;
    @(negedge clock);

    // Zero input
    launch(0);
    drain(40);

    // Back-to-back: start held high through the done cycle
    bin_in = BW'(12345);
    start  = 1'b1;
    sb.push_back(make_exp(12345, cyc + 1 + LAT));
    @(posedge clock);
    @(negedge clock);
    bin_in = BW'(99999);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    sb.push_back(make_exp(99999, cyc + 1 + LAT));
    @(negedge clock);
    start = 1'b0;
    drain(40);

    // Saturating inputs
    launch(100000);
    drain(40);
    launch(131071);
    drain(40);

    // Start during busy is ignored
    launch(42);
    repeat (4) @(negedge clock);
    bin_in = BW'(7);
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    drain(40);
    repeat (25) @(negedge clock);

    // Reset mid-conversion discards work
    launch(54321);
    repeat (8) @(negedge clock);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midconv_reset");
    sb.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (25) @(negedge clock);
    launch(54321);
    drain(40);

    // Random sweep
    repeat (25) begin
      launch($urandom_range(0, 99999));
      drain(40);
    end
    repeat (4) begin
      launch($urandom_range(100000, 131071));
      drain(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
